systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_ctrl.sv | 113 +++++++++++
 tb/tb_systolic_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array controller.
package systolic_pkg;

  localparam int DIM_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_ctrl.sv
// Sequencer for one DIM x DIM matrix-multiply pass:
// clear accumulators row by row, stream skewed A/B feeds, then pulse done.
// Pure control; no operand data passes through here.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int KW  = $clog2(3*DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [DIM-1:0] clr_row_wren,
  output logic           mac_en,
  output logic [KW-1:0]  k_idx,
  output logic [DIM-1:0] a_row_vld,
  output logic [DIM-1:0] b_col_vld
);

  // Terminal counts; the counter never wraps, these compares end each phase.
  localparam logic [KW-1:0] CLR_LAST = KW'(DIM - 1);
  localparam logic [KW-1:0] CMP_LAST = KW'(3*DIM - 3);

  state_t        state, state_nx;
  logic [KW-1:0] cnt, cnt_nx;
  logic [DIM-1:0] skew_vld;

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state plus Moore outputs decoded from state/counter only.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    busy         = 1'b0;
    done         = 1'b0;
    clr_row_wren = '0;
    mac_en       = 1'b0;
    k_idx        = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      S_CLEAR: begin
        busy         = 1'b1;
        clr_row_wren = {{(DIM-1){1'b0}}, 1'b1} << cnt;
        if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CLR_LAST) begin
          state_nx = S_COMPUTE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_COMPUTE: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        k_idx  = cnt;
        if (abort) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CMP_LAST) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE: begin
        // abort is deliberately not looked at here: the pass already finished.
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Diagonal skew: lane i is live for DIM cycles starting at k_idx == i.
  // k_idx is already 0 outside COMPUTE, so mac_en gates the idle case.
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    always_comb begin
      skew_vld[i] = mac_en &&
                    ({1'b0, k_idx} >= (KW+1)'(i)) &&
                    ({1'b0, k_idx} <  (KW+1)'(i + DIM));
    end
  end

  // Rows of A and columns of B share the same skew pattern.
  assign a_row_vld = skew_vld;
  assign b_col_vld = skew_vld;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl at DIM=4.
module tb_systolic_ctrl;

  localparam int DIM = 4;
  localparam int KW  = $clog2(3*DIM);

  logic           clk, rst_n, start, abort;
  logic           busy, done, mac_en;
  logic [DIM-1:0] clr_row_wren, a_row_vld, b_col_vld;
  logic [KW-1:0]  k_idx;

  int checks   = 0;
  int failures = 0;

  systolic_ctrl #(.DIM(DIM), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .clr_row_wren(clr_row_wren),
    .mac_en(mac_en), .k_idx(k_idx), .a_row_vld(a_row_vld),
    .b_col_vld(b_col_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d,
                         input logic [3:0] clr, input logic m,
                         input logic [3:0] k, input logic [3:0] v);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".clr"},  32'(clr_row_wren), 32'(clr));
    chk({tag, ".mac"},  32'(mac_en), 32'(m));
    chk({tag, ".k"},    32'(k_idx), 32'(k));
    chk({tag, ".avld"}, 32'(a_row_vld), 32'(v));
    chk({tag, ".bvld"}, 32'(b_col_vld), 32'(v));
  endtask

  // Hand-written expectations for busy cycle c = 1..15 of a DIM=4 pass.
  function automatic logic [3:0] exp_clr(input int c);
    case (c)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] exp_k(input int c);
    if (c >= 5 && c <= 14) return 4'(c - 5);
    return 4'd0;
  endfunction

  function automatic logic [3:0] exp_vld(input int c);
    case (c)
      5:  return 4'b0001;  // k=0
      6:  return 4'b0011;  // k=1
      7:  return 4'b0111;  // k=2
      8:  return 4'b1111;  // k=3
      9:  return 4'b1110;  // k=4
      10: return 4'b1100;  // k=5
      11: return 4'b1000;  // k=6
      default: return 4'b0000;
    endcase
  endfunction

  // Launch a pass from IDLE and check every busy cycle plus the IDLE that follows.
  task automatic run_pass(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      chk_all($sformatf("%s.c%0d", tag, c), 1'b1, (c == 15),
              exp_clr(c), (c >= 5 && c <= 14), exp_k(c), exp_vld(c));
      tick();
    end
    chk_all({tag, ".idle"}, 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    chk_all("reset", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("idle0", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);

    // Full pass, cycle by cycle.
    run_pass("pass1");

    // Abort during COMPUTE at k_idx=5.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("abort.k5", 32'(k_idx), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("abort.after", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);
    for (int c = 0; c < 8; c++) begin
      chk("abort.nodone", 32'(done), 32'd0);
      tick();
    end
    run_pass("post_abort");

    // start held high: done, exactly one IDLE, then CLEAR again.
    start = 1'b1;
    tick();
    for (int c = 1; c < 15; c++) tick();
    chk("b2b.done", 32'(done), 32'd1);
    tick();
    chk("b2b.idle_busy", 32'(busy), 32'd0);
    tick();
    chk("b2b.clr0", 32'(clr_row_wren), 32'b0001);
    chk("b2b.busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("b2b.done2", 32'(done), 32'd1);

    // abort during DONE is ignored: done seen, then normal return to IDLE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_all("abort_done.idle", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);

    // start together with abort in IDLE is accepted; abort then cancels in CLEAR.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_abort.clr0", 32'(clr_row_wren), 32'b0001);
    chk("idle_abort.busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    chk_all("clr_abort.idle", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);

    // start while busy is ignored and not queued.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start.clr2", 32'(clr_row_wren), 32'b0100);
    for (int c = 3; c < 15; c++) tick();
    chk("busy_start.done", 32'(done), 32'd1);
    tick();
    tick();
    chk("busy_start.noqueue", 32'(busy), 32'd0);

    // Asynchronous reset mid-CLEAR.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid.clr1", 32'(clr_row_wren), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid.async", 1'b0, 1'b0, 4'b0, 1'b0, 4'd0, 4'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("rst_mid.nodone", 32'(done | busy), 32'd0);
    end
    run_pass("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
